conv_pe: RTL and testbench

3×3 convolution processing element for the accelerator datapath. It receives one IFM column per cycle, 3 rows × Tin channels, and builds a 3-column sliding window. From that window and a Tin-channel filter set it computes Tout signed partial sums per output pixel, with zero-padding on image edges. The block sits between the buffer manager (IFM and filter feed) and the accumulator/output stage, under control of the top-level controller.

---
 rtl/conv_pe.sv | 252 +++++++++++++++++++++++++
 tb/tb_conv_pe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe.sv
// conv_pe: 3x3 convolution processing element.
//
// Builds a 3-column sliding window from one IFM column per cycle (3 rows x
// Tin channels). On each compute it applies the edge-padding mask to the
// window and produces Tout signed partial sums, one per filter. Each sum
// covers Tin channels x 9 taps.
//
// Pipeline (compute sampled at edge n, result at edge n+PE_DELAY):
//   stage 1 (edge n)   : masked window + active weights registered
//   stage 2 (edge n+1) : 16-bit products
//   stage 3 (edge n+2) : per-channel 9-tap sums
//   stage 4 (edge n+3) : per-filter channel sums
//   output  (edge n+4) : o_acc / o_vld
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   c_ctrl_data_run                shift incoming column into the window (L<-C<-R<-in)
//   c_top_cal_start                compute one pixel from the window as it stands
//   c_is_first_row / c_is_last_row zero window row 0 / row 2 for this compute
//   c_is_first_col / c_is_last_col zero window column L / R for this compute
//   bm_ifm_data_flat               K rows of IFM words, row r at [(r+1)*IFM_DW-1 -: IFM_DW]
//   load_filter, load_idx          write kernel set for input channel load_idx
//   bm_filter_data_flat            Tout kernels, filter t at [(t+1)*FILTER_DW-1 -: FILTER_DW]
//   change_filter                  copy shadow bank to active bank
//   o_acc, o_vld                   Tout partial sums and their one-cycle valid
//
// Configuration macro: CONV_PE_DBUF_EN
//   defined   : shadow + active filter banks; change_filter copies shadow->active
//   undefined : single bank written directly by load_filter; change_filter ignored
module conv_pe #(
    parameter int K         = 3,
    parameter int W_DATA    = 8,
    parameter int W_KERNEL  = 8,
    parameter int Tin       = 4,
    parameter int Tout      = 4,
    parameter int W_PSUM    = 32,
    parameter int IFM_DW    = Tin * W_DATA,
    parameter int FILTER_DW = K * K * W_KERNEL
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   c_ctrl_data_run,
    input  logic                   c_top_cal_start,
    input  logic                   c_is_first_row,
    input  logic                   c_is_last_row,
    input  logic                   c_is_first_col,
    input  logic                   c_is_last_col,
    input  logic [K*IFM_DW-1:0]    bm_ifm_data_flat,
    input  logic                   load_filter,
    input  logic [1:0]             load_idx,
    input  logic [Tout*FILTER_DW-1:0] bm_filter_data_flat,
    input  logic                   change_filter,
    output logic [Tout*W_PSUM-1:0] o_acc,
    output logic                   o_vld
);

    // Latency is fixed by the stage structure below.
    localparam int PE_DELAY = 4;
    localparam int W_PROD   = W_DATA + W_KERNEL;

    // One window cell: all channels of one (row, column) position.
    typedef logic [Tin-1:0][W_DATA-1:0]                      cell_t;
    // Window indexed [row][col]; col 0 = L, 1 = C, K-1 = R.
    typedef cell_t [K-1:0][K-1:0]                            win_t;
    // One 3x3 kernel indexed [ky][kx]; matches the flat filter bit layout.
    typedef logic [K-1:0][K-1:0][W_KERNEL-1:0]               kern_t;
    typedef kern_t [Tout-1:0][Tin-1:0]                       bank_t;
    typedef logic [Tout-1:0][Tin-1:0][K-1:0][K-1:0][W_PROD-1:0] prod_t;
    typedef logic [Tout-1:0][Tin-1:0][W_PSUM-1:0]            chsum_t;
    typedef logic [Tout-1:0][W_PSUM-1:0]                     psum_t;

    win_t                win_q,    win_d;
    bank_t               active_q, active_d;
`ifdef CONV_PE_DBUF_EN
    bank_t               shadow_q, shadow_d;
`endif
    win_t                s1_act_q, s1_act_d;
    bank_t               s1_w_q,   s1_w_d;
    prod_t               prod_q,   prod_d;
    chsum_t              chsum_q,  chsum_d;
    psum_t               tsum_q,   tsum_d;
    logic [PE_DELAY-1:0] vld_q,    vld_d;
    psum_t               o_acc_q,  o_acc_d;
    logic                o_vld_q,  o_vld_d;

    // ------------------------------------------------------------------
    // Sliding window
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win_d = win_q;
        if (c_ctrl_data_run) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K - 1; k++) begin
                    win_d[r][k] = win_q[r][k+1];
                end
                win_d[r][K-1] = bm_ifm_data_flat[r*IFM_DW +: IFM_DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Filter banks
    // ------------------------------------------------------------------
`ifdef CONV_PE_DBUF_EN
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        // The copy reads shadow_q, so a load in the same cycle is not seen
        // by the active bank but still lands in the shadow bank.
        if (change_filter) begin
            active_d = shadow_q;
        end
        if (load_filter) begin
            for (int t = 0; t < Tout; t++) begin
                shadow_d[t][load_idx] = bm_filter_data_flat[t*FILTER_DW +: FILTER_DW];
            end
        end
    end
`else
    always_comb begin
        active_d = active_q;
        if (load_filter) begin
            for (int t = 0; t < Tout; t++) begin
                active_d[t][load_idx] = bm_filter_data_flat[t*FILTER_DW +: FILTER_DW];
            end
        end
    end

    // Single-bank build has nothing to swap.
    logic unused_change_filter;
    assign unused_change_filter = change_filter;
`endif

    // ------------------------------------------------------------------
    // Stage 1: apply edge padding and capture the weights. Capturing the
    // weights here keeps in-flight computes immune to change_filter.
    // ------------------------------------------------------------------
    always_comb begin
        s1_act_d = win_q;
        s1_w_d   = active_q;
        for (int k = 0; k < K; k++) begin
            if (c_is_first_row) s1_act_d[0][k]   = '0;
            if (c_is_last_row)  s1_act_d[K-1][k] = '0;
            if (c_is_first_col) s1_act_d[k][0]   = '0;
            if (c_is_last_col)  s1_act_d[k][K-1] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed 8x8 products. Operands are sign-extended to the
    // product width so the low W_PROD bits are the exact signed product.
    // ------------------------------------------------------------------
    always_comb begin
        prod_d = '0;
        for (int t = 0; t < Tout; t++) begin
            for (int c = 0; c < Tin; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        prod_d[t][c][r][k] = W_PROD'($signed(s1_act_q[r][k][c]))
                                           * W_PROD'($signed(s1_w_q[t][c][r][k]));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: per-channel sum of the 9 taps, sign-extended to W_PSUM.
    // ------------------------------------------------------------------
    always_comb begin
        chsum_d = '0;
        for (int t = 0; t < Tout; t++) begin
            for (int c = 0; c < Tin; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        chsum_d[t][c] = chsum_d[t][c]
                                      + W_PSUM'($signed(prod_q[t][c][r][k]));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: per-filter sum over input channels.
    // ------------------------------------------------------------------
    always_comb begin
        tsum_d = '0;
        for (int t = 0; t < Tout; t++) begin
            for (int c = 0; c < Tin; c++) begin
                tsum_d[t] = tsum_d[t] + chsum_q[t][c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid tracking and output register. o_acc holds between results.
    // ------------------------------------------------------------------
    always_comb begin
        vld_d   = {vld_q[PE_DELAY-2:0], c_top_cal_start};
        o_vld_d = vld_q[PE_DELAY-1];
        o_acc_d = o_acc_q;
        if (vld_q[PE_DELAY-1]) begin
            o_acc_d = tsum_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q    <= '0;
            // NOTE: the filter banks are flop arrays, not RAM, so they take
            // the reset too; a compute before any load then yields zero.
            active_q <= '0;
`ifdef CONV_PE_DBUF_EN
            shadow_q <= '0;
`endif
            s1_act_q <= '0;
            s1_w_q   <= '0;
            prod_q   <= '0;
            chsum_q  <= '0;
            tsum_q   <= '0;
            vld_q    <= '0;
            o_acc_q  <= '0;
            o_vld_q  <= 1'b0;
        end else begin
            win_q    <= win_d;
            active_q <= active_d;
`ifdef CONV_PE_DBUF_EN
            shadow_q <= shadow_d;
`endif
            s1_act_q <= s1_act_d;
            s1_w_q   <= s1_w_d;
            prod_q   <= prod_d;
            chsum_q  <= chsum_d;
            tsum_q   <= tsum_d;
            vld_q    <= vld_d;
            o_acc_q  <= o_acc_d;
            o_vld_q  <= o_vld_d;
        end
    end

    assign o_acc = o_acc_q;
    assign o_vld = o_vld_q;

endmodule

// File: tb/tb_conv_pe.sv
// Directed testbench for conv_pe. Inputs change and outputs are sampled on
// the falling clock edge; the DUT captures on the rising edge.
module tb_conv_pe;

    localparam int K    = 3;
    localparam int TIN  = 4;
    localparam int TOUT = 4;
    localparam int FDW  = K * K * 8;

    logic                  clk;
    logic                  rstn;
    logic                  c_ctrl_data_run;
    logic                  c_top_cal_start;
    logic                  c_is_first_row;
    logic                  c_is_last_row;
    logic                  c_is_first_col;
    logic                  c_is_last_col;
    logic [K*TIN*8-1:0]    bm_ifm_data_flat;
    logic                  load_filter;
    logic [1:0]            load_idx;
    logic [TOUT*FDW-1:0]   bm_filter_data_flat;
    logic                  change_filter;
    logic [TOUT*32-1:0]    o_acc;
    logic                  o_vld;

    int n_checks;
    int n_errors;

    conv_pe dut (
        .clk                 (clk),
        .rstn                (rstn),
        .c_ctrl_data_run     (c_ctrl_data_run),
        .c_top_cal_start     (c_top_cal_start),
        .c_is_first_row      (c_is_first_row),
        .c_is_last_row       (c_is_last_row),
        .c_is_first_col      (c_is_first_col),
        .c_is_last_col       (c_is_last_col),
        .bm_ifm_data_flat    (bm_ifm_data_flat),
        .load_filter         (load_filter),
        .load_idx            (load_idx),
        .bm_filter_data_flat (bm_filter_data_flat),
        .change_filter       (change_filter),
        .o_acc               (o_acc),
        .o_vld               (o_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
                     tag, got, $signed(got), exp, $signed(exp));
        end
    endtask

    // Stimulus pattern: activation for (column, row, channel), range -11..11.
    function automatic int act_f(input int col, input int row, input int ch);
        return ((col * 7 + row * 3 + ch * 5) % 23) - 11;
    endfunction

    // Weight pattern for (filter, channel, ky, kx), range -4..4.
    function automatic int wgt_f(input int t, input int c, input int ky, input int kx);
        return ((t * 5 + c * 3 + ky * 7 + kx * 2) % 9) - 4;
    endfunction

    // f = {first_row, last_row, first_col, last_col}
    task automatic set_flags(input logic [3:0] f);
        c_is_first_row = f[3];
        c_is_last_row  = f[2];
        c_is_first_col = f[1];
        c_is_last_col  = f[0];
    endtask

    task automatic fill_window(input logic [7:0] a);
        for (int i = 0; i < K; i++) begin
            c_ctrl_data_run  = 1'b1;
            bm_ifm_data_flat = {K*TIN{a}};
            @(negedge clk);
        end
        c_ctrl_data_run = 1'b0;
    endtask

    task automatic load_bank(input logic [7:0] w, input bit change_on_last);
        for (int c = 0; c < TIN; c++) begin
            load_filter         = 1'b1;
            load_idx            = 2'(c);
            bm_filter_data_flat = {TOUT*K*K{w}};
            change_filter       = change_on_last && (c == TIN - 1);
            @(negedge clk);
        end
        load_filter   = 1'b0;
        change_filter = 1'b0;
    endtask

    task automatic swap_bank();
        change_filter = 1'b1;
        @(negedge clk);
        change_filter = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] w);
        load_bank(w, 1'b0);
        swap_bank();
    endtask

    task automatic drive_col(input int col);
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < TIN; c++) begin
                bm_ifm_data_flat[r*TIN*8 + c*8 +: 8] = 8'(act_f(col, r, c));
            end
        end
    endtask

    // One compute; every lane is expected to equal exp.
    task automatic run_pixel(input string tag, input logic [3:0] f, input logic [31:0] exp);
        int lat;
        c_top_cal_start = 1'b1;
        set_flags(f);
        @(negedge clk);
        c_top_cal_start = 1'b0;
        set_flags(4'b0000);
        lat = 0;
        while (!o_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        for (int t = 0; t < TOUT; t++) begin
            check($sformatf("%s lane%0d", tag, t), o_acc[t*32 +: 32], exp);
        end
        @(negedge clk);
        check({tag, " vld one cycle"}, 32'(o_vld), 32'd0);
        check({tag, " acc held"}, o_acc[31:0], exp);
    endtask

    int          exp_stream[16][TOUT];
    logic [31:0] dbuf_exp;
    logic [31:0] same_cycle_exp;
    logic        saw_vld;

    initial begin
        n_checks            = 0;
        n_errors            = 0;
        rstn                = 1'b0;
        c_ctrl_data_run     = 1'b0;
        c_top_cal_start     = 1'b0;
        set_flags(4'b0000);
        bm_ifm_data_flat    = '0;
        load_filter         = 1'b0;
        load_idx            = '0;
        bm_filter_data_flat = '0;
        change_filter       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset vld", 32'(o_vld), 32'd0);
        for (int t = 0; t < TOUT; t++) begin
            check($sformatf("reset acc lane%0d", t), o_acc[t*32 +: 32], 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Interior pixel and edge padding with all-ones data and weights
        load_all(8'h01);
        fill_window(8'h01);
        run_pixel("interior", 4'b0000, 32'd36);
        run_pixel("first_row", 4'b1000, 32'd24);
        run_pixel("first_row_col", 4'b1010, 32'd16);
        run_pixel("last_row_col", 4'b0101, 32'd16);
        run_pixel("all_flags", 4'b1111, 32'd4);

        // Signed arithmetic
        load_all(8'hFF);
        fill_window(8'h7F);
        run_pixel("neg_weights", 4'b0000, 32'hFFFF_EE24);
        load_all(8'h80);
        fill_window(8'h80);
        run_pixel("min_times_min", 4'b0000, 32'd589824);

        // Filter banking
        load_all(8'h01);
        fill_window(8'h01);
        load_bank(8'h00, 1'b0);
`ifdef CONV_PE_DBUF_EN
        dbuf_exp       = 32'd36;
        same_cycle_exp = 32'd27;
`else
        dbuf_exp       = 32'd0;
        same_cycle_exp = 32'd36;
`endif
        run_pixel("load_no_swap", 4'b0000, dbuf_exp);
        swap_bank();
        run_pixel("after_swap", 4'b0000, 32'd0);
        // Swap on the same cycle as the channel-3 load: the copy misses it.
        load_bank(8'h01, 1'b1);
        run_pixel("swap_with_load", 4'b0000, same_cycle_exp);
        swap_bank();
        run_pixel("swap_after_load", 4'b0000, 32'd36);

        // Streaming: prefill columns 0..2, then 16 back-to-back computes
        // while columns 3..18 shift in. Compute j sees columns j, j+1, j+2.
        for (int j = 0; j < 16; j++) begin
            for (int t = 0; t < TOUT; t++) begin
                int s;
                s = 0;
                for (int c = 0; c < TIN; c++) begin
                    for (int ky = 0; ky < K; ky++) begin
                        for (int kx = 0; kx < K; kx++) begin
                            if (!((j == 0 && kx == 0) || (j == 15 && kx == 2))) begin
                                s += act_f(j + kx, ky, c) * wgt_f(t, c, ky, kx);
                            end
                        end
                    end
                end
                exp_stream[j][t] = s;
            end
        end
        for (int c = 0; c < TIN; c++) begin
            load_filter = 1'b1;
            load_idx    = 2'(c);
            for (int t = 0; t < TOUT; t++) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        bm_filter_data_flat[t*FDW + (ky*K + kx)*8 +: 8] = 8'(wgt_f(t, c, ky, kx));
                    end
                end
            end
            @(negedge clk);
        end
        load_filter = 1'b0;
        swap_bank();
        for (int col = 0; col < K; col++) begin
            c_ctrl_data_run = 1'b1;
            drive_col(col);
            @(negedge clk);
        end
        for (int i = 0; i < 22; i++) begin
            if (i >= 5 && i < 21) begin
                check($sformatf("stream vld %0d", i - 5), 32'(o_vld), 32'd1);
                for (int t = 0; t < TOUT; t++) begin
                    check($sformatf("stream px%0d lane%0d", i - 5, t),
                          o_acc[t*32 +: 32], 32'(exp_stream[i-5][t]));
                end
            end else begin
                check($sformatf("stream idle vld %0d", i), 32'(o_vld), 32'd0);
            end
            if (i < 16) begin
                c_ctrl_data_run = 1'b1;
                c_top_cal_start = 1'b1;
                drive_col(i + K);
                set_flags({2'b00, i == 0, i == 15});
            end else begin
                c_ctrl_data_run = 1'b0;
                c_top_cal_start = 1'b0;
                set_flags(4'b0000);
            end
            @(negedge clk);
        end

        // Reset while results are in flight
        for (int i = 0; i < 5; i++) begin
            c_ctrl_data_run = 1'b1;
            c_top_cal_start = 1'b1;
            drive_col(i);
            @(negedge clk);
        end
        check("pre-reset vld", 32'(o_vld), 32'd1);
        c_ctrl_data_run = 1'b0;
        c_top_cal_start = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("async reset vld", 32'(o_vld), 32'd0);
        for (int t = 0; t < TOUT; t++) begin
            check($sformatf("async reset acc lane%0d", t), o_acc[t*32 +: 32], 32'd0);
        end
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        saw_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_vld = saw_vld | o_vld;
            @(negedge clk);
        end
        check("no stale vld", 32'(saw_vld), 32'd0);
        fill_window(8'h01);
        run_pixel("filters cleared", 4'b0000, 32'd0);
        load_all(8'h01);
        run_pixel("reloaded", 4'b0000, 32'd36);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
